// File: rtl/pipearch_common_pkg.sv
// Shared CCI-P definitions for the pipeline arbiters: tag/counter widths,
// instance ceiling and the c0 read request header layout.
package pipearch_common;

  localparam int unsigned CCIP_TAG_W         = 2;
  localparam int unsigned CCIP_MAX_INSTANCES = 4;
  localparam int unsigned CCIP_CNT_W         = 8;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c0_ReqMemHdr;

  // Requester index lives in the top mdata bits so responses can be routed back.
  function automatic logic [15:0] tag_mdata(input logic [15:0]           mdata,
                                            input logic [CCIP_TAG_W-1:0] tag);
    return {tag, mdata[15-CCIP_TAG_W:0]};
  endfunction

endpackage

// File: rtl/ccip_rd_arbiter_rr_select.sv
// Round-robin one-hot selector: first eligible index at or after ptr, wrapping.
module rr_select
  import pipearch_common::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]            eligible,
  input  logic [CCIP_TAG_W-1:0]   ptr,
  output logic [N-1:0]            grant
);

  logic [2*N-1:0] rot_wide;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] back_wide;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_wide  = {eligible, eligible} >> ptr;
    rot       = rot_wide[N-1:0];
    first     = rot & (~rot + N'(1));
    back_wide = {first, first} << ptr;
    grant     = back_wide[2*N-1:N];
  end

endmodule

// File: rtl/ccip_rd_arbiter.sv
// Round-robin arbiter for CCI-P c0 read requests with per-requester in-flight
// accounting. Define CCIP_RD_ARB_CREDIT_LIMIT_EN to cap each requester at MAX_OUTSTANDING.
module ccip_rd_arbiter
  import pipearch_common::*;
#(
  parameter int unsigned NUM_INSTANCES   = 4,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_INSTANCES-1:0]                    req_valid,
  input  t_ccip_c0_ReqMemHdr [NUM_INSTANCES-1:0]      req_hdr,
  output logic [NUM_INSTANCES-1:0]                    req_ready,
  input  logic                                        c0TxAlmFull,
  output logic                                        tx_valid,
  output t_ccip_c0_ReqMemHdr                          tx_hdr,
  input  logic                                        rsp_valid,
  input  logic [CCIP_TAG_W-1:0]                       rsp_tag,
  output logic [NUM_INSTANCES-1:0][CCIP_CNT_W-1:0]    outstanding,
  output logic                                        tag_err
);

  typedef logic [CCIP_CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  logic [CCIP_TAG_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                         tx_valid_q, tx_valid_d;
  t_ccip_c0_ReqMemHdr           tx_hdr_q, tx_hdr_d;
  cnt_t [NUM_INSTANCES-1:0]     cnt_q, cnt_d;
  logic                         tag_err_q, tag_err_d;

  logic [NUM_INSTANCES-1:0]     eligible;
  logic [NUM_INSTANCES-1:0]     grant;
  logic [NUM_INSTANCES-1:0]     rsp_hit;
  logic [CCIP_TAG_W-1:0]        grant_idx;
  t_ccip_c0_ReqMemHdr           grant_hdr;

  always_comb begin
    eligible = req_valid & {NUM_INSTANCES{~c0TxAlmFull}};
`ifdef CCIP_RD_ARB_CREDIT_LIMIT_EN
    for (int unsigned i = 0; i < NUM_INSTANCES; i++) begin
      if (cnt_q[i] == CCIP_CNT_W'(MAX_OUTSTANDING)) eligible[i] = 1'b0;
    end
`endif
  end

  rr_select #(
    .N (NUM_INSTANCES)
  ) u_rr_select (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .grant    (grant)
  );

  assign req_ready = reset ? '0 : grant;

  always_comb begin
    grant_idx = '0;
    grant_hdr = '0;
    rsp_hit   = '0;
    for (int unsigned i = 0; i < NUM_INSTANCES; i++) begin
      if (grant[i]) begin
        grant_idx = CCIP_TAG_W'(i);
        grant_hdr = req_hdr[i];
      end
      rsp_hit[i] = rsp_valid && (32'(rsp_tag) == i);
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    tx_valid_d = |grant;
    tx_hdr_d   = tx_hdr_q;
    cnt_d      = cnt_q;
    tag_err_d  = tag_err_q;

    if (|grant) begin
      tx_hdr_d       = grant_hdr;
      tx_hdr_d.mdata = tag_mdata(grant_hdr.mdata, grant_idx);
      rr_ptr_d       = (32'(grant_idx) == NUM_INSTANCES - 1) ? '0
                                                             : grant_idx + CCIP_TAG_W'(1);
    end

    if (rsp_valid && (32'(rsp_tag) >= NUM_INSTANCES)) tag_err_d = 1'b1;

    // A response to an empty counter is dropped (flagged); a grant in the same
    // cycle still counts. Increment saturates rather than wrapping.
    for (int unsigned i = 0; i < NUM_INSTANCES; i++) begin
      if (rsp_hit[i] && (cnt_q[i] == '0)) tag_err_d = 1'b1;
      if (grant[i] && !(rsp_hit[i] && (cnt_q[i] != '0))) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CCIP_CNT_W'(1);
      end else if (!grant[i] && rsp_hit[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CCIP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_hdr_q   <= '0;
      cnt_q      <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tx_valid_q <= tx_valid_d;
      tx_hdr_q   <= tx_hdr_d;
      cnt_q      <= cnt_d;
      tag_err_q  <= tag_err_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_hdr      = tx_hdr_q;
  assign outstanding = cnt_q;
  assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Self-checking bench for ccip_rd_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural model. Honours CCIP_RD_ARB_CREDIT_LIMIT_EN.
module tb_ccip_rd_arbiter;
  import pipearch_common::*;

  localparam int N = 4;
`ifdef CCIP_RD_ARB_CREDIT_LIMIT_EN
  localparam int MAX_OUT = 4;
  localparam bit CREDIT  = 1'b1;
`else
  localparam int MAX_OUT = 64;
  localparam bit CREDIT  = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          reset;
  logic [N-1:0]                  req_valid;
  t_ccip_c0_ReqMemHdr [N-1:0]    req_hdr;
  logic [N-1:0]                  req_ready;
  logic                          c0TxAlmFull;
  logic                          tx_valid;
  t_ccip_c0_ReqMemHdr            tx_hdr;
  logic                          rsp_valid;
  logic [1:0]                    rsp_tag;
  logic [N-1:0][7:0]             outstanding;
  logic                          tag_err;

  always #5 clk = ~clk;

  ccip_rd_arbiter #(
    .NUM_INSTANCES   (N),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_hdr     (req_hdr),
    .req_ready   (req_ready),
    .c0TxAlmFull (c0TxAlmFull),
    .tx_valid    (tx_valid),
    .tx_hdr      (tx_hdr),
    .rsp_valid   (rsp_valid),
    .rsp_tag     (rsp_tag),
    .outstanding (outstanding),
    .tag_err     (tag_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int                 m_cnt [N];
  int                 m_ptr;
  logic               m_txv;
  t_ccip_c0_ReqMemHdr m_hdr;
  logic               m_err;
  logic [N-1:0]       last_ready;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic t_ccip_c0_ReqMemHdr rand_hdr();
    t_ccip_c0_ReqMemHdr h;
    h          = '0;
    h.cl_len   = 2'($urandom());
    h.req_type = 4'($urandom());
    h.address  = 42'({$urandom(), $urandom()});
    h.mdata    = 16'($urandom());
    return h;
  endfunction

  function automatic int model_grant(input logic [N-1:0] v, input logic af);
    if (af) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (v[idx] && !(CREDIT && m_cnt[idx] >= MAX_OUT)) return idx;
    end
    return -1;
  endfunction

  task automatic run_cycle(input logic rst, input logic [N-1:0] v, input logic af,
                           input logic rv, input logic [1:0] rt, input int m0);
    int                 g;
    logic [N-1:0]       exp_rdy;
    t_ccip_c0_ReqMemHdr hdrs [N];
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      hdrs[i] = rand_hdr();
      if (i == 0 && m0 >= 0) hdrs[i].mdata = 16'(m0);
      req_hdr[i] = hdrs[i];
    end
    reset = rst; req_valid = v; c0TxAlmFull = af; rsp_valid = rv; rsp_tag = rt;
    g       = model_grant(v, af);
    exp_rdy = (rst || g < 0) ? '0 : N'(1 << g);
    #1;
    last_ready = req_ready;
    check("req_ready", req_ready, exp_rdy);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ptr = 0; m_txv = 1'b0; m_hdr = '0; m_err = 1'b0;
    end else begin
      if (rv && (int'(rt) >= N || m_cnt[rt] == 0)) m_err = 1'b1;
      for (int i = 0; i < N; i++) begin
        int delta;
        delta = 0;
        if (g == i) delta++;
        if (rv && int'(rt) == i && m_cnt[i] > 0) delta--;
        m_cnt[i] = m_cnt[i] + delta;
        if (m_cnt[i] > 255) m_cnt[i] = 255;
      end
      m_txv = (g >= 0);
      if (g >= 0) begin
        m_hdr       = hdrs[g];
        m_hdr.mdata = {2'(g), hdrs[g].mdata[13:0]};
        m_ptr       = (g + 1) % N;
      end
    end
    #1;
    check("tx_valid", tx_valid, m_txv);
    check("tx_hdr", tx_hdr, m_hdr);
    check("tag_err", tag_err, m_err);
    for (int i = 0; i < N; i++)
      check($sformatf("outstanding[%0d]", i), outstanding[i], m_cnt[i]);
  endtask

  task automatic do_reset();
    run_cycle(1'b1, '1, 1'b0, 1'b0, 2'd0, -1);
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         af;
    logic [N-1:0] exp_rdy;
    logic         exp_txv;
    logic [1:0]   exp_tag;
  } vec_t;
  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] v;
    logic         af, rv;
    logic [1:0]   rt;
    int           g;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'b1111, 1'b0, N'(1 << (i % 4)), 1'b1, 2'(i % 4)};
    for (int i = 8; i < 13; i++)
      tbl[i] = '{4'b0110, 1'b1, 4'b0000, 1'b0, 2'd3};
    tbl[13] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 2'd1};
    tbl[14] = '{4'b0110, 1'b0, 4'b0100, 1'b1, 2'd2};

    reset = 1'b1; req_valid = '0; c0TxAlmFull = 1'b0; rsp_valid = 1'b0; rsp_tag = '0;
    req_hdr = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_txv = 1'b0; m_hdr = '0; m_err = 1'b0;

    // Reset state, with requests held high
    do_reset();
    do_reset();
    check("reset_ready", last_ready, 4'b0000);
    check("reset_txv", tx_valid, 1'b0);
    check("reset_outstanding", outstanding, '0);
    check("reset_tag_err", tag_err, 1'b0);

    // Single requester
    run_cycle(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 16'h1234);
    check("single_txv", tx_valid, 1'b1);
    check("single_mdata", tx_hdr.mdata, 16'h1234);
    check("single_out0", outstanding[0], 8'd1);

    // Table: full rotation then backpressure window and release
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_cycle(1'b0, tbl[i].v, tbl[i].af, 1'b0, 2'd0, -1);
      check($sformatf("tbl%0d_ready", i), last_ready, tbl[i].exp_rdy);
      check($sformatf("tbl%0d_txv", i), tx_valid, tbl[i].exp_txv);
      check($sformatf("tbl%0d_tag", i), tx_hdr.mdata[15:14], tbl[i].exp_tag);
    end

    // Simultaneous grant and response, then underflow
    do_reset();
    repeat (3) run_cycle(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, -1);
    check("sim_pre_out2", outstanding[2], 8'd3);
    run_cycle(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, -1);
    check("sim_ready2", last_ready, 4'b0100);
    check("sim_out2", outstanding[2], 8'd3);
    check("sim_no_err", tag_err, 1'b0);
    run_cycle(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, -1);
    check("underflow_err", tag_err, 1'b1);
    check("underflow_out3", outstanding[3], 8'd0);

    // Mid-operation reset with counts (5,2,0,1); credit mode caps requester 0 at 4
    do_reset();
    repeat (5) run_cycle(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, -1);
    repeat (2) run_cycle(1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, -1);
    run_cycle(1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, -1);
    check("mid_out0", outstanding[0], 8'(CREDIT ? 4 : 5));
    check("mid_out1", outstanding[1], 8'd2);
    check("mid_out3", outstanding[3], 8'd1);
    run_cycle(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, -1);
    check("mid_rst_out", outstanding, '0);
    check("mid_rst_txv", tx_valid, 1'b0);
    run_cycle(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, -1);
    check("mid_rst_ptr0", last_ready, 4'b0001);

`ifdef CCIP_RD_ARB_CREDIT_LIMIT_EN
    do_reset();
    repeat (4) run_cycle(1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, -1);
    check("credit_out1", outstanding[1], 8'd4);
    run_cycle(1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, -1);
    check("credit_blocked", last_ready, 4'b0000);
    run_cycle(1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, -1);
    check("credit_blocked_rsp", last_ready, 4'b0000);
    run_cycle(1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, -1);
    check("credit_regrant", last_ready, 4'b0010);
`else
    do_reset();
    repeat (260) run_cycle(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, -1);
    check("sat_out0", outstanding[0], 8'd255);
    check("sat_txv", tx_valid, 1'b1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      v  = N'($urandom());
      af = ($urandom_range(0, 4) == 0);
      g  = model_grant(v, af);
      rv = 1'b0;
      rt = 2'($urandom());
      if ($urandom_range(0, 3) != 0) begin
        if (m_cnt[rt] > 0) rv = 1'b1;
        else if (g != int'(rt) && $urandom_range(0, 15) == 0) rv = 1'b1;
      end
      run_cycle($urandom_range(0, 199) == 0, v, af, rv, rt, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
